// File: rtl/adis_pkg.sv
// Shared constants, FSM state encoding and address helpers for the ADIS16209
// register-interface responder.
package adis_pkg;

   localparam int FRAME_BITS = 16;
   localparam int W_BIT      = 15;
   localparam int IDX_W      = 6;

   localparam logic [IDX_W-1:0] REG_TEMP  = 6'd6;
   localparam logic [IDX_W-1:0] REG_XINCL = 6'd7;
   localparam logic [IDX_W-1:0] REG_ROT   = 6'd37;

   typedef enum logic [1:0] {
      ST_WAIT_HIGH = 2'd0,
      ST_IDLE      = 2'd1,
      ST_SHIFT     = 2'd2,
      ST_DONE      = 2'd3
   } adis_state_e;

   // Registers are 16-bit words addressed by byte; bit 0 selects the byte.
   function automatic logic [IDX_W-1:0] word_index(input logic [6:0] byte_addr);
      return byte_addr[6:1];
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchroniser for an asynchronous pin with one-cycle rise/fall
// pulses taken from a single history flop behind the last stage.
module spi_edge_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_adis_responder.sv
// SPI mode-3 slave emulating the ADIS16209 register file: reads answer one
// frame late, writes update single bytes, and a local port loads whole words.
module spi_adis_responder
   import adis_pkg::*;
#(
   parameter int NUM_WORDS   = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   input  logic        upd_valid,
   input  logic [5:0]  upd_addr,
   input  logic [15:0] upd_data,
   output logic        frame_done,
   output logic        frame_abort,
   output logic [15:0] cmd_rx,
   output logic        wr_strobe,
   output adis_state_e dbg_state
);

   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   mosi_s;
   adis_state_e            state;
   logic [4:0]             bitcnt;
   logic [15:0]            rx_sr, tx_sr, tx_word;
   logic [15:0]            regs [64];
   logic                   decode, dec_wr, dec_in_range, upd_in_range;
   logic [IDX_W-1:0]       dec_idx;

   // sclk idles high so it resets high; cs_n resets low so a reset taken
   // mid-frame cannot be mistaken for the start of a fresh frame.
   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
      .clk(clk), .rst(rst), .din(sclk), .rise(sclk_rise), .fall(sclk_fall));

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
      .clk(clk), .rst(rst), .din(cs_n), .rise(cs_rise), .fall(cs_fall));

   always_ff @(posedge clk) begin
      if (rst) mosi_q <= '0;
      else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
   end
   assign mosi_s = mosi_q[SYNC_STAGES-1];

   assign decode       = (state == ST_SHIFT) && (bitcnt == 5'(FRAME_BITS));
   assign dec_wr       = decode && rx_sr[W_BIT];
   assign dec_idx      = word_index(rx_sr[14:8]);
   assign dec_in_range = int'(dec_idx) < NUM_WORDS;
   assign upd_in_range = int'(upd_addr) < NUM_WORDS;
   assign dbg_state    = state;

   // The SPI byte is assigned after the local word so it wins on a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) regs[i] <= '0;
      end else begin
         if (upd_valid && upd_in_range) regs[upd_addr] <= upd_data;
         if (dec_wr && dec_in_range) begin
            if (rx_sr[8]) regs[dec_idx][15:8] <= rx_sr[7:0];
            else          regs[dec_idx][7:0]  <= rx_sr[7:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_WAIT_HIGH;
         miso        <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         wr_strobe   <= 1'b0;
         cmd_rx      <= '0;
         tx_word     <= '0;
         rx_sr       <= '0;
         tx_sr       <= '0;
         bitcnt      <= '0;
      end else begin
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         wr_strobe   <= 1'b0;
         case (state)
            ST_WAIT_HIGH: begin
               miso <= 1'b0;
               if (cs_rise) state <= ST_IDLE;
            end
            ST_IDLE: begin
               miso <= 1'b0;
               if (cs_fall) begin
                  tx_sr  <= tx_word;
                  miso   <= tx_word[15];
                  bitcnt <= '0;
                  state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (decode) begin
                  frame_done <= 1'b1;
                  cmd_rx     <= rx_sr;
                  wr_strobe  <= rx_sr[W_BIT];
                  if (!rx_sr[W_BIT]) tx_word <= dec_in_range ? regs[dec_idx] : 16'h0000;
                  miso       <= 1'b0;
                  state      <= ST_DONE;
               end else if (cs_rise) begin
                  frame_abort <= 1'b1;
                  miso        <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  if (sclk_rise) begin
                     rx_sr  <= {rx_sr[14:0], mosi_s};
                     bitcnt <= bitcnt + 5'd1;
                  end
                  // The first fall re-drives bit 15, later falls advance one bit.
                  if (sclk_fall) begin
                     miso  <= tx_sr[15];
                     tx_sr <= {tx_sr[14:0], 1'b0};
                  end
               end
            end
            ST_DONE: begin
               miso <= 1'b0;
               if (cs_rise) state <= ST_IDLE;
            end
            default: state <= ST_WAIT_HIGH;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_adis_responder.sv
// Directed bench for spi_adis_responder: a 64-word and a 32-word instance share
// the SPI pins so out-of-range behaviour shows up on the second one's miso.
module tb_spi_adis_responder;
   import adis_pkg::*;

   logic        clk = 1'b0;
   logic        rst, sclk, cs_n, mosi;
   logic        upd_valid;
   logic [5:0]  upd_addr;
   logic [15:0] upd_data;
   logic        miso, frame_done, frame_abort, wr_strobe;
   logic [15:0] cmd_rx;
   adis_state_e dbg_state;
   logic        miso32, frame_done32, frame_abort32, wr_strobe32;
   logic [15:0] cmd_rx32;
   adis_state_e dbg_state32;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_cnt = 0, wr_cnt = 0, abort_cnt = 0;
   logic [15:0] rd, rd32;

   always #5 clk = ~clk;

   spi_adis_responder #(.NUM_WORDS(64), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
      .frame_done(frame_done), .frame_abort(frame_abort), .cmd_rx(cmd_rx),
      .wr_strobe(wr_strobe), .dbg_state(dbg_state));

   spi_adis_responder #(.NUM_WORDS(32), .SYNC_STAGES(2)) dut32 (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso32),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
      .frame_done(frame_done32), .frame_abort(frame_abort32), .cmd_rx(cmd_rx32),
      .wr_strobe(wr_strobe32), .dbg_state(dbg_state32));

   always @(negedge clk) begin
      if (frame_done)  done_cnt++;
      if (wr_strobe)   wr_cnt++;
      if (frame_abort) abort_cnt++;
   end

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic upd(input logic [5:0] a, input logic [15:0] d);
      upd_valid = 1'b1; upd_addr = a; upd_data = d;
      clk_n(1);
      upd_valid = 1'b0;
      clk_n(1);
   endtask

   // One master frame: sclk low/high 6 clk each, miso sampled just before each rise.
   task automatic spi_frame(input logic [15:0] w, output logic [15:0] r, output logic [15:0] r32,
                            input int nbits, input int rst_at, input bit upd_last);
      r = '0; r32 = '0;
      cs_n = 1'b0;
      clk_n(6);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1; clk_n(3); rst = 1'b0; clk_n(2);
         end
         sclk = 1'b0; mosi = w[15-i];
         clk_n(6);
         r[15-i] = miso; r32[15-i] = miso32;
         sclk = 1'b1;
         if (upd_last && i == 15) begin
            // Rise is acted on 3 edges later; decode happens on the 4th edge.
            clk_n(3);
            upd_valid = 1'b1; upd_addr = REG_XINCL; upd_data = 16'hAAAA;
            clk_n(1);
            upd_valid = 1'b0;
            check("same_cycle_done", {15'b0, frame_done}, 16'h0001);
            clk_n(2);
         end else begin
            clk_n(6);
         end
      end
      clk_n(2);
      cs_n = 1'b1;
      clk_n(10);
   endtask

   task automatic frame(input logic [15:0] w);
      spi_frame(w, rd, rd32, 16, -1, 1'b0);
   endtask

   initial begin
      rst = 1'b1; sclk = 1'b1; cs_n = 1'b1; mosi = 1'b0;
      upd_valid = 1'b0; upd_addr = '0; upd_data = '0;
      clk_n(4);
      check("rst_miso", {15'b0, miso}, 16'h0000);
      check("rst_frame_done", {15'b0, frame_done}, 16'h0000);
      check("rst_frame_abort", {15'b0, frame_abort}, 16'h0000);
      check("rst_wr_strobe", {15'b0, wr_strobe}, 16'h0000);
      check("rst_cmd_rx", cmd_rx, 16'h0000);
      check("rst_state", {14'b0, dbg_state}, 16'h0000);
      rst = 1'b0;
      clk_n(6);
      check("idle_after_rst", {14'b0, dbg_state}, 16'h0001);

      // Read latency: the first read answers with the reset tx word.
      upd(REG_TEMP, 16'h1234);
      frame(16'h0C00);
      check("first_read", rd, 16'h0000);
      frame(16'h0E00);
      check("temp_read", rd, 16'h1234);
      check("done_cnt_2", 16'(done_cnt), 16'd2);
      check("cmd_rx_0e00", cmd_rx, 16'h0E00);
      check("no_wr_yet", 16'(wr_cnt), 16'd0);

      // Byte writes low then high into word 7.
      frame(16'h8EAB);
      check("wr_lo_miso", rd, 16'h0000);
      frame(16'h8FCD);
      check("wr_cnt_2", 16'(wr_cnt), 16'd2);
      frame(16'h0E00);
      frame(16'h0000);
      check("xincl_read", rd, 16'hCDAB);
      check("wr_cnt_still_2", 16'(wr_cnt), 16'd2);
      check("done_cnt_6", 16'(done_cnt), 16'd6);

      // Word 37 and 63 exist only in the 64-word instance.
      upd(REG_ROT, 16'hBEEF);
      upd(6'd63, 16'h5A5A);
      frame(16'h4A00);
      frame(16'h0000);
      check("rot_read", rd, 16'hBEEF);
      check("rot_oor32", rd32, 16'h0000);
      frame(16'h7E00);
      frame(16'h0200);
      check("w63_read", rd, 16'h5A5A);
      check("w63_oor32", rd32, 16'h0000);

      // Abort after 9 bits of a write.
      spi_frame(16'h8E55, rd, rd32, 9, -1, 1'b0);
      check("abort_cnt", 16'(abort_cnt), 16'd1);
      check("abort_no_done", 16'(done_cnt), 16'd10);
      check("abort_cmd_rx", cmd_rx, 16'h0200);
      frame(16'h0E00);
      frame(16'h0200);
      check("abort_word7", rd, 16'hCDAB);
      check("after_abort_done", 16'(done_cnt), 16'd12);

      // Reset at bit 8 with cs_n held low.
      spi_frame(16'h8E99, rd, rd32, 16, 8, 1'b0);
      check("midrst_no_done", 16'(done_cnt), 16'd12);
      check("midrst_miso_bits", rd, 16'h0000);
      check("midrst_miso", {15'b0, miso}, 16'h0000);
      check("midrst_cmd_rx", cmd_rx, 16'h0000);
      check("midrst_state", {14'b0, dbg_state}, 16'h0001);
      frame(16'h0E00);
      check("post_rst_done", 16'(done_cnt), 16'd13);
      check("post_rst_cmd", cmd_rx, 16'h0E00);
      frame(16'h0200);
      check("post_rst_word7", rd, 16'h0000);

      // Local update collides with an SPI low-byte write to word 7.
      spi_frame(16'h8E77, rd, rd32, 16, -1, 1'b1);
      check("collide_wr_cnt", 16'(wr_cnt), 16'd3);
      frame(16'h0E00);
      frame(16'h0200);
      check("collide_word7", rd, 16'hAA77);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_adis_responder.md
# spi_adis_responder

SPI slave that emulates the ADIS16209 register interface on `sclk`/`mosi`/`miso`/`cs_n` (mode 3, 16-bit frames, MSB first). It is the far end of `spi_adis16209` and lets the acquisition and UART/SPRAM path be exercised in simulation and on a loop-back board without the sensor. It holds a 16-bit-word register file that a local stimulus port updates; SPI reads return it, SPI writes modify it byte-wise.

## Interface
- `NUM_WORDS`, 64: register-file depth in 16-bit words; word index = `addr[6:1]`.
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `cs_n`, `mosi`.
- `clk` in 1: system clock (`clk_42mhz` domain). One clock only.
- `rst` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock from master, idles high (CPOL=1); asynchronous to `clk`.
- `cs_n` in 1: active-low frame select.
- `mosi` in 1: master data, sampled on `sclk` rising edge.
- `miso` out 1: slave data, changes after `sclk` falling edge; 0 when idle.
- `upd_valid` in 1: local register-update strobe.
- `upd_addr` in 6: word index for update.
- `upd_data` in 16: word value for update.
- `frame_done` out 1: one-cycle pulse, a complete 16-bit frame was decoded.
- `frame_abort` out 1: one-cycle pulse, `cs_n` rose before 16 bits.
- `cmd_rx` out 16: last complete frame received, held until next complete frame.
- `wr_strobe` out 1: one-cycle pulse, concurrent with `frame_done` when the frame was a write.

## Operation
- Frame format: bit15 = W (1 write, 0 read), bits[14:8] = byte address, bits[7:0] = write data (ignored for reads).
- Read: word `reg[addr[6:1]]` is latched into `tx_word` at decode; it is shifted out in the NEXT frame (one-frame latency, as on the sensor). Index ≥ `NUM_WORDS` → `tx_word` = 16'h0000.
- Write: `addr[0]`=0 writes low byte, =1 writes high byte of `reg[addr[6:1]]`; `tx_word` unchanged. Out-of-range index: discarded, pulses still issued.
- `upd_valid`: `reg[upd_addr] <= upd_data` (out-of-range ignored). Same-cycle SPI write to same word: the SPI byte wins, the other byte takes `upd_data`.
- FSM: `WAIT_HIGH` (after reset; leave when synced `cs_n`=1 → `IDLE`), `IDLE` (on `cs_n` fall: load shifter from `tx_word`, `miso` = bit15, bitcnt=0 → `SHIFT`), `SHIFT` (sclk rise: shift in `mosi`, bitcnt+1; sclk fall: shift out next bit; bitcnt reaches 16 → decode, → `DONE`), `DONE` (extra sclk edges ignored, `miso`=0; `cs_n` rise → `IDLE`).
- `cs_n` rise in `SHIFT`: `frame_abort`, no decode, no register change, → `IDLE`.
- Reset mid-frame: all state cleared; → `WAIT_HIGH`, so the truncated frame is never decoded.
- Reset values: `miso`=0, `frame_done`=0, `frame_abort`=0, `wr_strobe`=0, `cmd_rx`=0, `tx_word`=0, all `reg`=0.

## Timing
- Inputs pass `SYNC_STAGES` flops then a one-flop edge detector: edge seen `SYNC_STAGES`+1 `clk` after the pin.
- `miso` updates one `clk` after the detected `sclk` fall (≤ 4 `clk` after the pin edge for default depth).
- Requirement on master: `sclk` high and low ≥ 4 `clk` each; `cs_n` fall to first `sclk` fall ≥ 4 `clk`; last `sclk` rise to `cs_n` rise ≥ 2 `clk`.
- Decode occurs the cycle after the 16th detected rise; `frame_done`, `wr_strobe`, `cmd_rx`, register write and `tx_word` update all become visible on the same edge.
- `upd_valid` is written on the next `clk` edge; a read decoded in that cycle returns the pre-update value.

## Structure
- Package `adis_pkg`: `FRAME_BITS`=16, W-bit position, FSM state enum, register index constants (`REG_TEMP`=6, `REG_XINCL`=7, `REG_ROT`=37, matching byte addresses 0x0C/0x0E/0x4A).
- Sub-module `spi_edge_sync`: N-stage synchroniser plus rise/fall pulse outputs, instantiated for `sclk` and `cs_n`; `mosi` uses a plain synchroniser.

## Test plan
- Reset, `upd` word 6 = 16'h1234, frames 16'h0C00 then 16'h0E00 → second frame MISO = 16'h1234; first MISO = 16'h0000; two `frame_done`, `cmd_rx`=16'h0E00.
- Write frames 16'h8EAB, 16'h8FCD, read 16'h0E00, dummy → dummy frame returns 16'hCDAB; `wr_strobe` on first two only.
- Read 16'h4A00 with word 37 = 16'hBEEF, next frame → 16'hBEEF; read 16'h7E00 with `NUM_WORDS`=32 → 16'h0000.
- Raise `cs_n` after 9 bits of 16'h8E55 → `frame_abort`, word 7 unchanged, `cmd_rx` unchanged, next full frame decodes normally.
- Assert `rst` at bit 8 of a frame, release with `cs_n` low, finish clocking → no `frame_done`, `miso`=0; next frame after `cs_n` high decodes.
- Same-cycle decode of 16'h8E77 and `upd_valid` word 7 = 16'hAAAA → word 7 = 16'hAA77.
